// File: rtl/countdown16_8ch_posedge_sync_reset_pkg.sv
// ---------------------------------------------------------------------------
// countdown16_8ch_posedge_sync_reset_pkg
//
// Shared defaults and helpers for the eight-channel down-counter bank.
//   WIDTH_DEFAULT     : counter width of one channel
//   NCH_DEFAULT       : number of channels in the bank
//   RESET_VAL_DEFAULT : count / reload value after reset
//   chan_lsb()        : lowest bit of channel 'ch' in a packed per-channel bus
// ---------------------------------------------------------------------------
package countdown16_8ch_posedge_sync_reset_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int NCH_DEFAULT   = 8;

    localparam logic [15:0] RESET_VAL_DEFAULT = 16'hFFFF;

    // Channel i occupies bits [chan_lsb(i, width) +: width] of every packed bus.
    function automatic int chan_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/countdown16_8ch_posedge_sync_reset_countdown16.sv
// ---------------------------------------------------------------------------
// countdown16
//
// One loadable down counter channel with a reload register.
//   clk      : clock, all state changes on posedge
//   reset    : synchronous active-high reset
//   load     : load strobe, copies load_val into count and reload register
//   load_val : value to load
//   en       : count enable
//   cnt      : current count
//   tc       : one-cycle pulse, high in the cycle cnt first reads 0 after a
//              decrement
//   zero     : high while cnt == 0
// ---------------------------------------------------------------------------
module countdown16 #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VAL   = '1,
    parameter bit               AUTO_RELOAD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] reload_reg;

    // Count, reload register and terminal-count pulse. Priority is reset,
    // then load, then enable. tc defaults low each edge so it can only be a
    // single-cycle pulse; it is set only by the 1 -> 0 step, so loading 0 or
    // sitting at 0 never raises it. At zero with enable, the counter either
    // reloads or parks at 0; it never wraps to all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= RESET_VAL;
            reload_reg <= RESET_VAL;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                cnt        <= load_val;
                reload_reg <= load_val;
            end else if (en) begin
                if (cnt > ONE) begin
                    cnt <= cnt - ONE;
                end else if (cnt == ONE) begin
                    cnt <= '0;
                    tc  <= 1'b1;
                end else if (AUTO_RELOAD) begin
                    cnt <= reload_reg;
                end
            end
        end
    end

    // Zero flag follows the count register directly.
    assign zero = (cnt == '0);

endmodule

// File: rtl/countdown16_8ch_posedge_sync_reset.sv
// ---------------------------------------------------------------------------
// countdown16_8ch_posedge_sync_reset
//
// Bank of NCH independent loadable down counters used as tick generators.
//   clk      : single clock
//   reset    : synchronous active-high reset
//   load     : per-channel load strobe            [NCH]
//   load_val : packed load values                 [NCH*WIDTH]
//   en       : per-channel count enable           [NCH]
//   cnt      : packed current counts              [NCH*WIDTH]
//   tc       : per-channel terminal-count pulse   [NCH]
//   zero     : per-channel zero flag              [NCH]
// Channel i uses bits [i*WIDTH +: WIDTH] of load_val and cnt.
// ---------------------------------------------------------------------------
module countdown16_8ch_posedge_sync_reset
    import countdown16_8ch_posedge_sync_reset_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEFAULT,
    parameter int               NCH         = NCH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL   = RESET_VAL_DEFAULT[WIDTH-1:0],
    parameter bit               AUTO_RELOAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic [NCH-1:0]       en,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       zero
);

    // One counter per channel; channels share only clock and reset.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        countdown16 #(
            .WIDTH       (WIDTH),
            .RESET_VAL   (RESET_VAL),
            .AUTO_RELOAD (AUTO_RELOAD)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .load_val (load_val[chan_lsb(i, WIDTH) +: WIDTH]),
            .en       (en[i]),
            .cnt      (cnt[chan_lsb(i, WIDTH) +: WIDTH]),
            .tc       (tc[i]),
            .zero     (zero[i])
        );
    end

endmodule

// File: tb/tb_countdown16_8ch_posedge_sync_reset.sv
// ---------------------------------------------------------------------------
// tb_countdown16_8ch_posedge_sync_reset
//
// Scoreboard bench. Three instances: dut_a (default, auto reload), dut_b
// (stop at zero) and dut_c (4-bit, 2 channels, reset value 5, auto reload)
// so the reload register contents after reset can be seen within a few
// cycles. Stimulus pushes expected states; a monitor pops and compares them
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_countdown16_8ch_posedge_sync_reset;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_a, reset_b, reset_c;
    logic [7:0]   load_a, en_a, load_b, en_b;
    logic [127:0] load_val_a, load_val_b;
    logic [127:0] cnt_a, cnt_b;
    logic [7:0]   tc_a, zero_a, tc_b, zero_b;
    logic [1:0]   load_c, en_c, tc_c, zero_c;
    logic [7:0]   load_val_c, cnt_c;

    countdown16_8ch_posedge_sync_reset dut_a (
        .clk(clk), .reset(reset_a), .load(load_a), .load_val(load_val_a),
        .en(en_a), .cnt(cnt_a), .tc(tc_a), .zero(zero_a)
    );

    countdown16_8ch_posedge_sync_reset #(.AUTO_RELOAD(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .load(load_b), .load_val(load_val_b),
        .en(en_b), .cnt(cnt_b), .tc(tc_b), .zero(zero_b)
    );

    countdown16_8ch_posedge_sync_reset #(
        .WIDTH(4), .NCH(2), .RESET_VAL(4'h5), .AUTO_RELOAD(1'b1)
    ) dut_c (
        .clk(clk), .reset(reset_c), .load(load_c), .load_val(load_val_c),
        .en(en_c), .cnt(cnt_c), .tc(tc_c), .zero(zero_c)
    );

    typedef struct {
        string       name;
        int          dut;
        int          ch;
        logic [15:0] cnt;
        logic        tc;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Place a 16-bit value into channel ch of a packed 8-channel bus.
    function automatic logic [127:0] lv(input int ch, input logic [15:0] v);
        logic [127:0] r;
        r = '0;
        r[ch*16 +: 16] = v;
        return r;
    endfunction

    // Drive dut_a inputs and advance one clock; returns just after the edge.
    task automatic applyStimulus(input logic rst, input logic [7:0] ld,
                                 input logic [127:0] lvv, input logic [7:0] e);
        reset_a    = rst;
        load_a     = ld;
        load_val_a = lvv;
        en_a       = e;
        @(posedge clk);
        #1;
    endtask

    // Queue the state expected after the edge just taken.
    task automatic checkOutput(input string name, input int dut, input int ch,
                               input logic [15:0] c, input logic t, input logic z);
        exp_t e;
        e.name = name; e.dut = dut; e.ch = ch; e.cnt = c; e.tc = t; e.zero = z;
        sb.push_back(e);
    endtask

    // Monitor: on each falling edge, compare every pending expectation.
    initial begin
        exp_t        e;
        logic [15:0] ac;
        logic        at, az;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0:       begin ac = cnt_a[e.ch*16 +: 16]; at = tc_a[e.ch]; az = zero_a[e.ch]; end
                    1:       begin ac = cnt_b[e.ch*16 +: 16]; at = tc_b[e.ch]; az = zero_b[e.ch]; end
                    default: begin ac = {12'h000, cnt_c[e.ch*4 +: 4]}; at = tc_c[e.ch]; az = zero_c[e.ch]; end
                endcase
                checks++;
                if (ac !== e.cnt || at !== e.tc || az !== e.zero) begin
                    errors++;
                    $display("[TB] FAIL %s dut%0d ch%0d: got cnt=%h tc=%b zero=%b, expected cnt=%h tc=%b zero=%b",
                             e.name, e.dut, e.ch, ac, at, az, e.cnt, e.tc, e.zero);
                end
            end
        end
    end

    logic [15:0] seq_cnt [8] = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
    logic        seq_tc  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  c_seq   [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};

    initial begin
        reset_b = 1'b1; load_b = '0; load_val_b = '0; en_b = '0;
        reset_c = 1'b1; load_c = '0; load_val_c = '0; en_c = '0;

        // Reset held two cycles with every enable high.
        applyStimulus(1'b1, 8'h00, '0, 8'hFF);
        applyStimulus(1'b1, 8'h00, '0, 8'hFF);
        for (int i = 0; i < 8; i++) checkOutput("reset_a", 0, i, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("reset_b", 1, 0, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("reset_c0", 2, 0, 16'h0005, 1'b0, 1'b0);
        checkOutput("reset_c1", 2, 1, 16'h0005, 1'b0, 1'b0);

        // Release reset; only ch0 enabled.
        reset_b = 1'b0; reset_c = 1'b0;
        applyStimulus(1'b0, 8'h00, '0, 8'h01);
        checkOutput("release_ch0", 0, 0, 16'hFFFE, 1'b0, 1'b0);
        checkOutput("release_ch1", 0, 1, 16'hFFFF, 1'b0, 1'b0);

        // Load 3 into ch0 with enable; load wins, then count with reload.
        applyStimulus(1'b0, 8'h01, lv(0, 16'd3), 8'h01);
        checkOutput("load3", 0, 0, 16'd3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'h00, '0, (i < 7) ? 8'h01 : 8'h00);
            checkOutput("count_reload", 0, 0, seq_cnt[i], seq_tc[i], seq_cnt[i] == 16'd0);
        end

        // Stop mode on dut_b: 2, 1, 0, 0, 0 with one tc pulse.
        load_b = 8'h01; load_val_b = lv(0, 16'd2); en_b = 8'h01;
        applyStimulus(1'b0, 8'h00, '0, 8'h00);
        checkOutput("stop_load", 1, 0, 16'd2, 1'b0, 1'b0);
        load_b = 8'h00;
        applyStimulus(1'b0, 8'h00, '0, 8'h00);
        checkOutput("stop_1", 1, 0, 16'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, '0, 8'h00);
        checkOutput("stop_tc", 1, 0, 16'd0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, '0, 8'h00);
            checkOutput("stop_hold", 1, 0, 16'd0, 1'b0, 1'b1);
        end
        en_b = 8'h00;

        // Priority on ch3: load beats enable; loading 0 never raises tc.
        applyStimulus(1'b0, 8'h08, lv(3, 16'd10), 8'h00);
        checkOutput("prio_load10", 0, 3, 16'd10, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h08, lv(3, 16'd500), 8'h08);
        checkOutput("prio_load500", 0, 3, 16'd500, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h08, lv(3, 16'd0), 8'h00);
        checkOutput("prio_load0", 0, 3, 16'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, '0, 8'h08);
        checkOutput("prio_zero_en", 0, 3, 16'd0, 1'b0, 1'b1);

        // Reset mid-count on ch5 at cnt=1 with enable: tc must not appear.
        applyStimulus(1'b0, 8'h20, lv(5, 16'd2), 8'h00);
        checkOutput("mid_load2", 0, 5, 16'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, '0, 8'h20);
        checkOutput("mid_at1", 0, 5, 16'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, '0, 8'h20);
        checkOutput("mid_reset5", 0, 5, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("mid_reset3", 0, 3, 16'hFFFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, '0, 8'h00);
        checkOutput("mid_after", 0, 5, 16'hFFFF, 1'b0, 1'b0);

        // Reload register restored by mid-count reset (dut_c, reset value 5).
        load_c = 2'b01; load_val_c = 8'h02; en_c = 2'b00;
        applyStimulus(1'b0, 8'h00, '0, 8'h00);
        checkOutput("c_load2", 2, 0, 16'd2, 1'b0, 1'b0);
        load_c = 2'b00; en_c = 2'b01;
        applyStimulus(1'b0, 8'h00, '0, 8'h00);
        checkOutput("c_at1", 2, 0, 16'd1, 1'b0, 1'b0);
        reset_c = 1'b1;
        applyStimulus(1'b0, 8'h00, '0, 8'h00);
        checkOutput("c_reset", 2, 0, 16'd5, 1'b0, 1'b0);
        reset_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, '0, 8'h00);
            checkOutput("c_reload", 2, 0, {12'h000, c_seq[i]}, i == 4, c_seq[i] == 4'd0);
        end
        en_c = 2'b00;
        checkOutput("c_ch1_idle", 2, 1, 16'd5, 1'b0, 1'b0);

        // Independence: ch1 enabled every other cycle, ch7 loaded and held.
        applyStimulus(1'b0, 8'h82, lv(1, 16'd100) | lv(7, 16'd200), 8'h00);
        checkOutput("ind_load1", 0, 1, 16'd100, 1'b0, 1'b0);
        checkOutput("ind_load7", 0, 7, 16'd200, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 8'h00, '0, (k % 2 == 0) ? 8'h02 : 8'h00);
            checkOutput("ind_ch1", 0, 1, 16'(100 - (k / 2 + 1)), 1'b0, 1'b0);
            checkOutput("ind_ch7", 0, 7, 16'd200, 1'b0, 1'b0);
        end
        checkOutput("ind_ch6", 0, 6, 16'hFFFF, 1'b0, 1'b0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
